debounce_bank: RTL

- Parametrised multi-channel input conditioner for board buttons, switches and external reset sources.
- Generalises the single-bit reset debouncer to CHANNELS independent lanes. Each lane has a configurable synchroniser depth and stability window.
- Adds per-lane rise/fall event pulses, sticky pending flags with masking and write-1-clear, and a registered interrupt output for the arbiter's interrupt controller.
- Sits between the top-level pads and the cpu/arbiter.

---
 rtl/debounce_bank.sv | 95 +++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Multi-lane input conditioner: per-lane synchroniser, stability-window debouncer,
// rise/fall pulses, sticky maskable pending flags and a registered interrupt.
module debounce_bank #(
   parameter int CHANNELS      = 8,
   parameter int CNT_WIDTH     = 16,
   parameter int STABLE_CYCLES = 50000,
   parameter int SYNC_STAGES   = 2,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] i_raw,
   input  logic [CHANNELS-1:0] i_mask_rise,
   input  logic [CHANNELS-1:0] i_mask_fall,
   input  logic [CHANNELS-1:0] i_clear,
   output logic [CHANNELS-1:0] o_level,
   output logic [CHANNELS-1:0] o_rise,
   output logic [CHANNELS-1:0] o_fall,
   output logic [CHANNELS-1:0] o_pending,
   output logic                o_int
);

   localparam logic [CHANNELS-1:0]  RESET_VEC = {CHANNELS{RESET_LEVEL}};
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);

   // Parameter sanity: the terminal count must be representable in the counter.
   if (CHANNELS < 1) begin : g_bad_channels
      $error("debounce_bank: CHANNELS must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_bank: SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 1 || ((STABLE_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_bad_window
      $error("debounce_bank: STABLE_CYCLES-1 must fit in CNT_WIDTH bits");
   end

   logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0]  sync;
   logic [CNT_WIDTH-1:0] cnt_q  [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_d  [CHANNELS];
   logic [CHANNELS-1:0]  toggle;
   logic [CHANNELS-1:0]  level_d;
   logic [CHANNELS-1:0]  rise_d;
   logic [CHANNELS-1:0]  fall_d;
   logic [CHANNELS-1:0]  pending_d;

   // NOTE: these stage arrays are a handful of flops, not RAM, so resetting every entry is cheap and keeps the lane level defined out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VEC;
      end else begin
         // NOTE: non-blocking so each stage captures the previous stage's old value, forming a true shift chain.
         sync_q[0] <= i_raw;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      // NOTE: every output of this block is given a default first so no path leaves a latch behind.
      toggle = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         if (sync[i] != o_level[i]) begin
            if (cnt_q[i] == CNT_LAST) toggle[i] = 1'b1;
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      level_d   = o_level ^ toggle;
      rise_d    = toggle & ~o_level;
      fall_d    = toggle & o_level;
      // Set term is OR'd after the clear so a same-edge event survives the clear.
      pending_d = (o_pending & ~i_clear) | (rise_d & i_mask_rise) | (fall_d & i_mask_fall);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
         o_level   <= RESET_VEC;
         o_rise    <= '0;
         o_fall    <= '0;
         o_pending <= '0;
         o_int     <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
         o_level   <= level_d;
         o_rise    <= rise_d;
         o_fall    <= fall_d;
         o_pending <= pending_d;
         o_int     <= |o_pending;
      end
   end

endmodule
